// File: rtl/cpu_run_ctrl.sv
// Run-control for the soft CPU: generates a registered clock-enable supporting
// free-run, counted stepping, PC breakpoints and external halt.
module cpu_run_ctrl #(
  parameter int unsigned STEP_W      = 16,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN_ALWAYS,
  input  logic              STEP_TRIG,
  input  logic [STEP_W-1:0] STEP_COUNT,
  input  logic              BRK_EN,
  input  logic [PC_W-1:0]   BRK_ADDR,
  input  logic [PC_W-1:0]   PC,
  input  logic              HALT_REQ,
  output logic              CPU_EN,
  output logic [1:0]        RUN_STATE,
  output logic              BRK_HIT,
  output logic [STEP_W-1:0] STEPS_LEFT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_STEP  = 2'b01,
    ST_FREE  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [SYNC_STAGES-1:0]  valid_q, valid_d;
  logic                    dly_q, dly_d;
  logic                    armed_q, armed_d;
  logic                    cpu_en_q, cpu_en_d;
  logic                    brk_hit_q, brk_hit_d;
  logic                    resume_q, resume_d;
  logic [STEP_W-1:0]       cnt_q, cnt_d;

  logic                    trig_last;
  logic                    step_rise;
  logic                    brk_match;
  logic                    enter;
  logic [STEP_W-1:0]       load_cnt;

  // valid_q tracks how far real samples have propagated down the chain, so a
  // button held through reset is never mistaken for a fresh low-to-high edge.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], STEP_TRIG};
    valid_d   = {valid_q[SYNC_STAGES-2:0], 1'b1};
    trig_last = sync_q[SYNC_STAGES-1];
    dly_d     = trig_last;
    armed_d   = armed_q | (valid_q[SYNC_STAGES-1] & ~trig_last);
    step_rise = armed_q & trig_last & ~dly_q;
    load_cnt  = (STEP_COUNT == '0) ? CNT_ONE : STEP_COUNT;
    brk_match = ((state_q == ST_STEP) || (state_q == ST_FREE)) & BRK_EN &
                cpu_en_q & (PC == BRK_ADDR) & ~resume_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    brk_hit_d = 1'b0;
    enter     = 1'b0;
    if (HALT_REQ) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (brk_match) begin
      state_d   = ST_BREAK;
      cnt_d     = '0;
      brk_hit_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (RUN_ALWAYS) begin
            state_d = ST_FREE;
            enter   = 1'b1;
          end else if (step_rise) begin
            state_d = ST_STEP;
            cnt_d   = load_cnt;
            enter   = 1'b1;
          end
        end
        ST_STEP: begin
          if (RUN_ALWAYS) begin
            state_d = ST_FREE;
            cnt_d   = '0;
            enter   = 1'b1;
          end else if (cnt_q == CNT_ONE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_FREE: begin
          if (!RUN_ALWAYS) state_d = ST_IDLE;
        end
        ST_BREAK: begin
          // RUN_ALWAYS must be dropped before the CPU can leave a breakpoint.
          if (!RUN_ALWAYS) begin
            if (step_rise) begin
              state_d = ST_STEP;
              cnt_d   = load_cnt;
              enter   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    cpu_en_d = (state_d == ST_STEP) || (state_d == ST_FREE);
    resume_d = enter;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      sync_q    <= '0;
      valid_q   <= '0;
      dly_q     <= 1'b0;
      armed_q   <= 1'b0;
      cpu_en_q  <= 1'b0;
      brk_hit_q <= 1'b0;
      resume_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      valid_q   <= valid_d;
      dly_q     <= dly_d;
      armed_q   <= armed_d;
      cpu_en_q  <= cpu_en_d;
      brk_hit_q <= brk_hit_d;
      resume_q  <= resume_d;
      cnt_q     <= cnt_d;
    end
  end

  assign CPU_EN     = cpu_en_q;
  assign RUN_STATE  = state_q;
  assign BRK_HIT    = brk_hit_q;
  assign STEPS_LEFT = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: vector table, directed corner
// sequences and a randomized run against a behavioural reference model.
module tb_cpu_run_ctrl;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n, run_always, step_trig, brk_en, halt_req;
  logic [15:0] step_count;
  logic [31:0] brk_addr, pc;
  logic        cpu_en, brk_hit;
  logic [1:0]  run_state;
  logic [15:0] steps_left;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.STEP_W(16), .PC_W(32), .SYNC_STAGES(S)) dut (
    .CLK(clk), .RST_N(rst_n), .RUN_ALWAYS(run_always), .STEP_TRIG(step_trig),
    .STEP_COUNT(step_count), .BRK_EN(brk_en), .BRK_ADDR(brk_addr), .PC(pc),
    .HALT_REQ(halt_req), .CPU_EN(cpu_en), .RUN_STATE(run_state),
    .BRK_HIT(brk_hit), .STEPS_LEFT(steps_left)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        trig, run, halt, ben;
    logic [15:0] cnt;
    logic [31:0] addr, pcv;
    logic        en;
    logic [1:0]  st;
    logic        hit;
    logic [15:0] left;
  } vec_t;

  function automatic vec_t mk(input logic trig, run, halt, ben, input logic [15:0] cnt,
                              input logic [31:0] addr, pcv, input logic en,
                              input logic [1:0] st, input logic hit, input logic [15:0] left);
    vec_t v;
    v.trig = trig; v.run = run; v.halt = halt; v.ben = ben; v.cnt = cnt;
    v.addr = addr; v.pcv = pcv; v.en = en; v.st = st; v.hit = hit; v.left = left;
    return v;
  endfunction

  // Reference model: synchronised trigger derived from a history of samples.
  int m_mode, m_left, m_age;
  bit m_hit;
  bit q[$];

  task automatic model_edge();
    int  j, prev;
    bit  rise, active, match;
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_hit = 0; m_age = 0;
      q.delete();
      return;
    end
    j    = q.size();
    rise = (j >= S + 1) && q[j-S] && !q[j-S-1];
    q.push_back(step_trig);
    active = (m_mode == 1) || (m_mode == 2);
    match  = active && brk_en && (pc == brk_addr) && (m_age != 0);
    prev   = m_mode;
    m_hit  = 0;
    if (halt_req) begin
      m_mode = 0; m_left = 0;
    end else if (match) begin
      m_mode = 3; m_left = 0; m_hit = 1;
    end else begin
      case (prev)
        0: if (run_always) m_mode = 2;
           else if (rise) begin m_mode = 1; m_left = (step_count == 0) ? 1 : int'(step_count); end
        1: if (run_always) begin m_mode = 2; m_left = 0; end
           else if (m_left == 1) begin m_mode = 0; m_left = 0; end
           else m_left = m_left - 1;
        2: if (!run_always) m_mode = 0;
        default: if (!run_always) begin
                   if (rise) begin m_mode = 1; m_left = (step_count == 0) ? 1 : int'(step_count); end
                   else m_mode = 0;
                 end
      endcase
    end
    if ((m_mode == 1 || m_mode == 2) && m_mode != prev) m_age = 0;
    else if (m_age < 2) m_age = m_age + 1;
  endtask

  initial begin
    vec_t tbl[13];
    bit   found, en_now;
    int   n_en, n_hit;
    logic [31:0] last_pc;

    rst_n = 0; run_always = 0; step_trig = 1; brk_en = 0; halt_req = 0;
    step_count = 0; brk_addr = 32'h40; pc = 0;

    // Button held through reset must not produce a step.
    repeat (3) tick();
    chk("reset_vals", {cpu_en, run_state, brk_hit, steps_left}, 0);
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("held_trig_no_step", {cpu_en, run_state}, 0);
    end
    step_trig = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("release_no_step", {cpu_en, run_state}, 0);
    end

    tbl[0]  = mk(1, 0, 0, 0, 0, 32'h40, 0,      0, 2'd0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 32'h40, 0,      0, 2'd0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 32'h40, 0,      1, 2'd1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 32'h40, 0,      0, 2'd0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 32'h40, 0,      1, 2'd2, 0, 0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 32'h40, 0,      0, 2'd0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 32'h40, 0,      1, 2'd2, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 32'h40, 0,      0, 2'd0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 1, 0, 32'h40, 32'h40, 1, 2'd2, 0, 0);
    tbl[9]  = mk(0, 1, 0, 1, 0, 32'h40, 32'h40, 1, 2'd2, 0, 0);
    tbl[10] = mk(0, 1, 0, 1, 0, 32'h40, 32'h40, 0, 2'd3, 1, 0);
    tbl[11] = mk(0, 1, 0, 1, 0, 32'h40, 32'h40, 0, 2'd3, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 0, 32'h40, 32'h40, 0, 2'd0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      step_trig = tbl[i].trig; run_always = tbl[i].run; halt_req = tbl[i].halt;
      brk_en = tbl[i].ben; step_count = tbl[i].cnt; brk_addr = tbl[i].addr; pc = tbl[i].pcv;
      tick();
      chk($sformatf("vec%0d", i), {cpu_en, run_state, brk_hit, steps_left},
          {tbl[i].en, tbl[i].st, tbl[i].hit, tbl[i].left});
    end

    // Free run with an incrementing PC into a breakpoint at 0x40.
    pc = 0; brk_en = 1; brk_addr = 32'h40; run_always = 1; step_count = 0;
    found = 0; last_pc = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      en_now  = cpu_en;
      last_pc = pc;
      tick();
      if (brk_hit) found = 1;
      else if (en_now) pc = pc + 4;
    end
    chk("brk_found", found, 1);
    chk("brk_pc", last_pc, 32'h40);
    chk("brk_state", {cpu_en, run_state}, {1'b0, 2'b11});
    tick();
    chk("brk_one_pulse", {brk_hit, run_state}, {1'b0, 2'b11});
    run_always = 0;
    tick();
    chk("brk_to_idle", {cpu_en, run_state}, 0);
    pc = 32'h40; step_trig = 1; n_en = 0; n_hit = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_en  += int'(cpu_en);
      n_hit += int'(brk_hit);
      if (c == 2) step_trig = 0;
    end
    chk("step_off_brk_en", n_en, 1);
    chk("step_off_brk_hit", n_hit, 0);
    brk_en = 0;

    // Five-cycle step; re-press and STEP_COUNT change mid-step have no effect.
    step_count = 5; step_trig = 1; found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      found = cpu_en;
    end
    chk("step5_start", found, 1);
    for (int i = 5; i >= 1; i--) begin
      chk("step5_left", {cpu_en, run_state, steps_left}, {1'b1, 2'b01, 16'(i)});
      if (i == 5) step_trig = 0;
      if (i == 4) begin step_trig = 1; step_count = 2; end
      if (i == 3) step_trig = 0;
      tick();
    end
    chk("step5_end", {cpu_en, run_state, steps_left}, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("step5_repress_ignored", {cpu_en, run_state}, 0);
    end

    // Reset asserted on the second cycle of a three-cycle step.
    step_count = 3; step_trig = 1; found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      found = cpu_en;
    end
    chk("step3_start", {found, steps_left}, {1'b1, 16'd3});
    step_trig = 0;
    tick();
    chk("step3_second", {cpu_en, steps_left}, {1'b1, 16'd2});
    rst_n = 0;
    tick();
    chk("rst_mid_step", {cpu_en, run_state, brk_hit, steps_left}, 0);
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_mid_no_enable", {cpu_en, run_state}, 0);
    end

    // Randomized run against the reference model.
    brk_addr = 32'h10;
    for (int i = 0; i < 1500; i++) begin
      rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 15) == 0) run_always = ~run_always;
      if ($urandom_range(0, 5) == 0)  step_trig  = ~step_trig;
      halt_req   = ($urandom_range(0, 19) == 0);
      brk_en     = $urandom_range(0, 1);
      pc         = ($urandom_range(0, 2) == 0) ? 32'h10 : 32'h14;
      step_count = 16'($urandom_range(0, 4));
      @(posedge clk);
      model_edge();
      #1;
      chk("model", {cpu_en, run_state, brk_hit, steps_left},
          {(m_mode == 1 || m_mode == 2), 2'(m_mode), m_hit, 16'(m_left)});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
